// File: rtl/reg_xfer_arbiter_pkg.sv
// rtl/reg_xfer_arbiter_pkg.sv - shared states, default sizes and helpers for the register transfer arbiter
//
// Purpose: FSM state encoding and default geometry shared by the arbiter,
//          its bus interface and the processor control unit.
// Ports:   none (package).
package reg_xfer_arbiter_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_N_REG  = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } xfer_state_e;

  // Width of an index into n items; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_xfer_arbiter_if.sv
// rtl/reg_xfer_arbiter_if.sv - requester and register-file bus bundle for the transfer arbiter
//
// Purpose: groups requester handshake and register strobe signals.
// Ports (signals):
//   req, req_src, req_dst              requester side, driven by master
//   grant, done                        requester side, driven by slave (arbiter)
//   reg_read, reg_write, bus_sel, busy register-file side, driven by slave
interface reg_xfer_arbiter_if
  import reg_xfer_arbiter_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int N_REG  = DEF_N_REG,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_src;
  logic [N_REQ*ADDR_W-1:0] req_dst;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        done;
  logic [N_REG-1:0]        reg_read;
  logic [N_REG-1:0]        reg_write;
  logic [ADDR_W-1:0]       bus_sel;
  logic                    busy;

  modport master (
    output req, req_src, req_dst,
    input  grant, done, reg_read, reg_write, bus_sel, busy
  );

  modport slave (
    input  req, req_src, req_dst,
    output grant, done, reg_read, reg_write, bus_sel, busy
  );

endinterface

// File: rtl/reg_xfer_arbiter_rr_pick.sv
// rtl/reg_xfer_arbiter_rr_pick.sv - combinational round-robin winner selection
//
// Purpose: finds the first set request bit scanning upward from ptr with wrap.
// Ports:
//   req        in   request vector
//   ptr        in   index where the scan starts
//   win_onehot out  one-hot winner (zero when no request)
//   win_idx    out  winner index (zero when no request)
//   valid      out  at least one request was found
module rr_pick
  import reg_xfer_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PTR_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [PTR_W-1:0] win_idx,
  output logic             valid
);

  int idx;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    valid      = 1'b0;
    idx        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!valid && req[idx]) begin
        valid           = 1'b1;
        win_idx         = PTR_W'(idx);
        win_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_xfer_arbiter.sv
// rtl/reg_xfer_arbiter.sv - round-robin arbiter sequencing register-to-register transfers
//
// Purpose: grants one requester at a time and runs a READ (source strobe)
//          then WRITE (destination strobe + done) cycle pair per transfer.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset
//   bus  slave modport of reg_xfer_arbiter_if (req/req_src/req_dst in;
//        grant/done/reg_read/reg_write/bus_sel/busy out)
module reg_xfer_arbiter
  import reg_xfer_arbiter_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int N_REG  = DEF_N_REG,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic               clk,
  input logic               rst,
  reg_xfer_arbiter_if.slave bus
);

  localparam int               PTR_W   = idx_w(N_REQ);
  localparam logic [N_REQ-1:0] REQ_ONE = N_REQ'(1);

  xfer_state_e       state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;

  logic [N_REQ-1:0]  owner_onehot;
  logic [N_REQ-1:0]  pick_req;
  logic [N_REQ-1:0]  win_onehot;
  logic [PTR_W-1:0]  win_idx;
  logic              win_valid;

  assign owner_onehot = REQ_ONE << owner_q;

  // The requester finishing in WRITE still has req high this cycle; masking it
  // stops it from being re-granted before it has seen its done pulse.
  always_comb begin
    pick_req = bus.req;
    if (state_q == ST_WRITE) begin
      pick_req = bus.req & ~owner_onehot;
    end
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req        (pick_req),
    .ptr        (rr_ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .valid      (win_valid)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    src_d    = src_q;
    dst_d    = dst_q;
    unique case (state_q)
      ST_READ: state_d = ST_WRITE;
      ST_IDLE, ST_WRITE: begin
        if (win_valid) begin
          state_d  = ST_READ;
          owner_d  = win_idx;
          src_d    = bus.req_src[win_idx*ADDR_W +: ADDR_W];
          dst_d    = bus.req_dst[win_idx*ADDR_W +: ADDR_W];
          rr_ptr_d = (win_idx == PTR_W'(N_REQ-1)) ? '0 : win_idx + PTR_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
    end
  end

  // Outputs decode purely from flops, so reset clears them without a clock.
  // An index beyond N_REG matches no strobe bit and the phase stays silent.
  always_comb begin
    bus.grant     = '0;
    bus.done      = '0;
    bus.reg_read  = '0;
    bus.reg_write = '0;
    bus.bus_sel   = src_q;
    bus.busy      = (state_q != ST_IDLE);
    if (state_q != ST_IDLE) begin
      bus.grant = owner_onehot;
    end
    if (state_q == ST_WRITE) begin
      bus.done = owner_onehot;
    end
    for (int r = 0; r < N_REG; r++) begin
      bus.reg_read[r]  = (state_q == ST_READ)  && (src_q == ADDR_W'(r));
      bus.reg_write[r] = (state_q == ST_WRITE) && (dst_q == ADDR_W'(r));
    end
  end

endmodule

// File: tb/tb_reg_xfer_arbiter.sv
// tb/tb_reg_xfer_arbiter.sv - self-checking bench for reg_xfer_arbiter
module tb_reg_xfer_arbiter;

  localparam int NQ = 4;
  localparam int NR = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_xfer_arbiter_if #(.N_REQ(NQ), .N_REG(NR), .ADDR_W(AW)) bus();

  reg_xfer_arbiter #(.N_REQ(NQ), .N_REG(NR), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level model: phase 0 = no transfer, 1 = source phase,
  // 2 = destination phase of the transfer owned by m_owner.
  int m_phase, m_owner, m_src, m_dst, m_ptr, m_bus_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_src = 0; m_dst = 0; m_ptr = 0; m_bus_sel = 0;
  endtask

  function automatic int slice_of(input logic [NQ*AW-1:0] v, input int i);
    return int'(v[i*AW +: AW]);
  endfunction

  function automatic logic [31:0] bit_if(input int b, input bit en);
    return en ? (32'd1 << b) : 32'd0;
  endfunction

  task automatic model_step();
    logic [NQ-1:0] cand;
    if (m_phase == 1) begin
      m_phase = 2;
      return;
    end
    cand = bus.req;
    if (m_phase == 2) cand[m_owner] = 1'b0;
    m_phase = 0;
    for (int k = 0; k < NQ; k++) begin
      int i;
      i = (m_ptr + k) % NQ;
      if (cand[i]) begin
        m_owner   = i;
        m_src     = slice_of(bus.req_src, i);
        m_dst     = slice_of(bus.req_dst, i);
        m_bus_sel = m_src;
        m_ptr     = (i + 1) % NQ;
        m_phase   = 1;
        break;
      end
    end
  endtask

  task automatic check_all();
    check("grant",     32'(bus.grant),     bit_if(m_owner, m_phase != 0));
    check("done",      32'(bus.done),      bit_if(m_owner, m_phase == 2));
    check("reg_read",  32'(bus.reg_read),  bit_if(m_src, m_phase == 1 && m_src < NR));
    check("reg_write", 32'(bus.reg_write), bit_if(m_dst, m_phase == 2 && m_dst < NR));
    check("bus_sel",   32'(bus.bus_sel),   32'(m_bus_sel));
    check("busy",      32'(bus.busy),      32'(m_phase != 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_all();
  endtask

  // Called at a negedge: asynchronous assert, hold across one edge, release.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input bit on, input int src, input int dst);
    bus.req[i] = on;
    bus.req_src[i*AW +: AW] = AW'(src);
    bus.req_dst[i*AW +: AW] = AW'(dst);
  endtask

  logic [NQ-1:0] exp_grants [10] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h1};

  initial begin
    bus.req = '0; bus.req_src = '0; bus.req_dst = '0;
    #1;
    model_reset();
    check_all();
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_busy",  32'(bus.busy),  32'h0);
    check("rst_bus_sel", 32'(bus.bus_sel), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single transfer 2 -> 5.
    set_req(0, 1'b1, 2, 5);
    cycle();
    check("t1_grant", 32'(bus.grant), 32'h1);
    check("t1_read",  32'(bus.reg_read), 32'h04);
    cycle();
    check("t1_write", 32'(bus.reg_write), 32'h20);
    check("t1_done",  32'(bus.done), 32'h1);
    bus.req = '0;
    cycle();
    check("t1_idle_busy", 32'(bus.busy), 32'h0);
    check("t1_idle_sel",  32'(bus.bus_sel), 32'h2);

    // Move pointer to 2 by serving requester 1, then 0 must beat 1.
    set_req(1, 1'b1, 0, 1);
    cycle(); cycle(); bus.req = '0; cycle();
    set_req(0, 1'b1, 1, 2);
    set_req(1, 1'b1, 3, 4);
    cycle();
    check("rr_first", 32'(bus.grant), 32'h1);
    cycle(); bus.req[0] = 1'b0;
    cycle();
    check("rr_second", 32'(bus.grant), 32'h2);
    cycle(); bus.req = '0;
    cycle();

    // Source change after latching is ignored.
    set_req(0, 1'b1, 3, 1);
    cycle();
    bus.req_src[0 +: AW] = AW'(6);
    cycle();
    check("latch_sel",   32'(bus.bus_sel), 32'h3);
    check("latch_write", 32'(bus.reg_write), 32'h02);
    bus.req = '0;
    cycle();

    // src == dst, then an out-of-range destination.
    set_req(3, 1'b1, 7, 7);
    cycle();
    check("same_read", 32'(bus.reg_read), 32'h80);
    cycle();
    check("same_write", 32'(bus.reg_write), 32'h80);
    bus.req = '0;
    cycle();
    set_req(3, 1'b1, 7, 9);
    cycle(); cycle();
    check("oor_write", 32'(bus.reg_write), 32'h0);
    check("oor_done",  32'(bus.done), 32'h8);
    bus.req = '0;
    cycle();

    // Reset during WRITE abandons the transfer; requester is re-served.
    set_req(2, 1'b1, 1, 4);
    cycle(); cycle();
    rst = 1'b1;
    #1;
    check("rw_async_write", 32'(bus.reg_write), 32'h0);
    check("rw_async_done",  32'(bus.done), 32'h0);
    check("rw_async_busy",  32'(bus.busy), 32'h0);
    model_reset();
    check_all();
    cycle();
    rst = 1'b0;
    cycle();
    check("rw_reserve", 32'(bus.grant), 32'h4);
    cycle(); bus.req = '0;
    cycle();

    // All requesters held high from reset.
    @(negedge clk);
    do_reset();
    bus.req = '1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      check("rr4_grant", 32'(bus.grant), 32'(exp_grants[c]));
      check("rr4_busy",  32'(bus.busy), 32'h1);
    end
    bus.req = '0;
    cycle();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NQ; i++) begin
        if (m_phase == 2 && m_owner == i) begin
          if ($urandom_range(0, 3) != 0) bus.req[i] = 1'b0;
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 2) == 0) set_req(i, 1'b1, $urandom_range(0, 9), $urandom_range(0, 9));
        end else if (m_phase != 0 && m_owner == i && $urandom_range(0, 7) == 0) begin
          bus.req[i] = 1'b0;
        end
        if ($urandom_range(0, 5) == 0) bus.req_src[i*AW +: AW] = AW'($urandom_range(0, 9));
        if ($urandom_range(0, 5) == 0) bus.req_dst[i*AW +: AW] = AW'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
